// File: rtl/integrate_feeder.sv
// Collects IN_NUM valid samples into one packed group for the adder tree and
// delays the group strobe by the tree depth so its sum can be sampled directly.
module integrate_feeder #(
  parameter int IN_NUM    = 8,
  parameter int BIT_WIDTH = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        in_start,
  input  logic                        in_valid,
  input  logic [BIT_WIDTH-1:0]        in_value,
  output logic [IN_NUM*BIT_WIDTH-1:0] out_values,
  output logic                        out_valid,
  output logic                        sum_valid,
  output logic                        dropped
);
  localparam int ADD_DEPTH = (IN_NUM > 1) ? $clog2(IN_NUM) : 0;
  localparam int CNT_W     = (IN_NUM > 1) ? $clog2(IN_NUM) : 1;
  localparam int VEC_W     = IN_NUM * BIT_WIDTH;
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(IN_NUM - 1);

  logic [CNT_W-1:0] cnt, cnt_next, wr_slot;
  logic [VEC_W-1:0] fill_buf, fill_next;
  logic             group_done;

  // Slot 0 is the first sample and lands at the MSB end of the vector.
  always_comb begin
    wr_slot    = in_start ? '0 : cnt;
    group_done = in_valid && (wr_slot == LAST_SLOT);
    fill_next  = fill_buf;
    cnt_next   = wr_slot;
    if (in_valid) begin
      for (int p = 0; p < IN_NUM; p++) begin
        if (wr_slot == CNT_W'(p))
          fill_next[(IN_NUM-1-p)*BIT_WIDTH +: BIT_WIDTH] = in_value;
      end
      cnt_next = group_done ? '0 : wr_slot + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt        <= '0;
      fill_buf   <= '0;
      out_values <= '0;
      out_valid  <= 1'b0;
      dropped    <= 1'b0;
    end else begin
      cnt       <= cnt_next;
      fill_buf  <= fill_next;
      out_valid <= group_done;
      dropped   <= in_start && (cnt != '0);
      if (group_done)
        out_values <= fill_next;
    end
  end

  generate
    if (ADD_DEPTH == 0) begin : g_no_delay
      assign sum_valid = out_valid;
    end else begin : g_delay
      logic [ADD_DEPTH-1:0] dly;
      always_ff @(posedge clock) begin
        if (reset) begin
          dly <= '0;
        end else begin
          dly[0] <= out_valid;
          for (int i = 1; i < ADD_DEPTH; i++)
            dly[i] <= dly[i-1];
        end
      end
      assign sum_valid = dly[ADD_DEPTH-1];
    end
  endgenerate

endmodule

// File: tb/tb_integrate_feeder.sv
// Bench for integrate_feeder: instances at IN_NUM 8, 1 and 5 share one stimulus
// stream and are compared every cycle against a group-collecting reference model.
module tb_integrate_feeder;
  logic         clock = 1'b0;
  logic         reset, in_start, in_valid;
  logic [15:0]  in_value;
  logic [127:0] ov8;
  logic [15:0]  ov1;
  logic [79:0]  ov5;
  logic [2:0]   oval, sval, drp;

  integrate_feeder #(.IN_NUM(8), .BIT_WIDTH(16)) u_n8 (
    .clock(clock), .reset(reset), .in_start(in_start), .in_valid(in_valid),
    .in_value(in_value), .out_values(ov8), .out_valid(oval[0]),
    .sum_valid(sval[0]), .dropped(drp[0]));
  integrate_feeder #(.IN_NUM(1), .BIT_WIDTH(16)) u_n1 (
    .clock(clock), .reset(reset), .in_start(in_start), .in_valid(in_valid),
    .in_value(in_value), .out_values(ov1), .out_valid(oval[1]),
    .sum_valid(sval[1]), .dropped(drp[1]));
  integrate_feeder #(.IN_NUM(5), .BIT_WIDTH(16)) u_n5 (
    .clock(clock), .reset(reset), .in_start(in_start), .in_valid(in_valid),
    .in_value(in_value), .out_values(ov5), .out_valid(oval[2]),
    .sum_valid(sval[2]), .dropped(drp[2]));

  always #5 clock = ~clock;

  localparam int NS[3] = '{8, 1, 5};
  localparam int DS[3] = '{3, 0, 3};
  localparam logic [127:0] V1 = 128'h0001_0002_0003_0004_0005_0006_0007_0008;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: samples gathered per group, pulse history per cycle.
  logic [15:0]  grp[3][8];
  int           nfill[3];
  logic [127:0] m_vec[3];
  bit           m_ov[3], m_dr[3], m_sv[3];
  bit           ov_hist[3][0:4095];
  bit           rst_hist[0:4095];

  typedef struct {
    bit          st;
    bit          v;
    logic [15:0] val;
    bit          e_ov;
    bit          e_drop;
  } vec_t;
  vec_t tv[11];

  task automatic chkv(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chkv(name, 128'(act), 128'(exp));
  endtask

  function automatic logic [15:0] tsum(input logic [127:0] v, input int n);
    logic [15:0] s = 16'd0;
    for (int p = 0; p < n; p++) s = s + v[p*16 +: 16];
    return s;
  endfunction

  function automatic logic [127:0] dut_vec(input int k);
    case (k)
      0:       return ov8;
      1:       return 128'(ov1);
      default: return 128'(ov5);
    endcase
  endfunction

  task automatic model_edge(input bit rst, input bit st, input bit v, input logic [15:0] val);
    rst_hist[cyc] = rst;
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        nfill[k] = 0; m_vec[k] = '0; m_ov[k] = 0; m_dr[k] = 0;
      end else begin
        m_dr[k] = st && (nfill[k] != 0);
        m_ov[k] = 0;
        if (st) nfill[k] = 0;
        if (v) begin
          grp[k][nfill[k]] = val;
          nfill[k]++;
          if (nfill[k] == NS[k]) begin
            m_vec[k] = '0;
            for (int p = 0; p < NS[k]; p++) m_vec[k] = (m_vec[k] << 16) | 128'(grp[k][p]);
            m_ov[k]  = 1;
            nfill[k] = 0;
          end
        end
      end
      ov_hist[k][cyc] = m_ov[k];
      if (DS[k] == 0) m_sv[k] = m_ov[k];
      else begin
        m_sv[k] = (cyc >= DS[k]) && ov_hist[k][cyc-DS[k]];
        for (int j = cyc - DS[k] + 1; j <= cyc; j++)
          if (j >= 0 && rst_hist[j]) m_sv[k] = 0;
      end
    end
  endtask

  task automatic step(input bit rst, input bit st, input bit v, input logic [15:0] val);
    reset = rst; in_start = st; in_valid = v; in_value = val;
    @(posedge clock);
    model_edge(rst, st, v, val);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk1($sformatf("out_valid_n%0d", NS[k]), oval[k], m_ov[k]);
      chk1($sformatf("sum_valid_n%0d", NS[k]), sval[k], m_sv[k]);
      chk1($sformatf("dropped_n%0d", NS[k]), drp[k], m_dr[k]);
      chkv($sformatf("out_values_n%0d", NS[k]), dut_vec(k), m_vec[k]);
    end
    cyc++;
  endtask

  initial begin
    int ovc[$];
    logic [15:0] sums[$];
    int n_ov, ov_c, sv_c;
    bit seen;
    reset = 1'b1; in_start = 1'b0; in_valid = 1'b0; in_value = '0;
    for (int i = 0; i < 3; i++) nfill[i] = 0;

    for (int i = 0; i < 11; i++) begin
      tv[i].st = (i == 3); tv[i].v = 1'b1;
      tv[i].val = (i < 3) ? 16'(i + 1) : 16'(i + 2);
      tv[i].e_ov = (i == 10); tv[i].e_drop = (i == 3);
    end

    // Reset state and test 1: samples 1..8 back-to-back.
    step(1, 0, 0, 0); step(1, 0, 0, 0);
    chkv("reset_out_values", ov8, 128'h0);
    chk1("reset_out_valid", oval[0], 1'b0);
    chk1("reset_sum_valid", sval[0], 1'b0);
    for (int i = 1; i <= 8; i++) begin
      step(0, 0, 1, 16'(i));
      chk1("n1_out_valid_every_cycle", oval[1], 1'b1);
      chk1("n1_sum_valid_coincident", sval[1], 1'b1);
      chk1("t1_out_valid", oval[0], i == 8);
    end
    chkv("t1_vector", ov8, V1);
    for (int i = 1; i <= 3; i++) begin
      step(0, 0, 0, 0);
      chk1("t1_sum_valid_latency", sval[0], i == 3);
    end
    chkv("t1_tree_sum", 128'(tsum(ov8, 8)), 128'd36);

    // Test 2: two groups back-to-back.
    step(1, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      if (i < 16) step(0, 0, 1, (i < 8) ? 16'(i + 1) : 16'((i - 7) * 10));
      else step(0, 0, 0, 0);
      if (oval[0]) ovc.push_back(cyc);
      if (sval[0]) sums.push_back(tsum(ov8, 8));
      if (i == 12) chkv("t2_vector_held", ov8, V1);
    end
    chkv("t2_out_valid_count", 128'(ovc.size()), 128'd2);
    chkv("t2_out_valid_spacing", (ovc.size() == 2) ? 128'(ovc[1] - ovc[0]) : 128'd0, 128'd8);
    chkv("t2_sum_count", 128'(sums.size()), 128'd2);
    chkv("t2_sum0", (sums.size() > 0) ? 128'(sums[0]) : 128'hx, 128'd36);
    chkv("t2_sum1", (sums.size() > 1) ? 128'(sums[1]) : 128'hx, 128'd360);

    // Test 3: in_valid alternating.
    step(1, 0, 0, 0);
    n_ov = 0;
    for (int i = 0; i < 18; i++) begin
      if (i < 16) step(0, 0, (i % 2) == 0, (i % 2 == 0) ? 16'(i / 2 + 1) : 16'hDEAD);
      else step(0, 0, 0, 0);
      if (oval[0]) n_ov++;
    end
    chkv("t3_out_valid_count", 128'(n_ov), 128'd1);
    chkv("t3_vector", ov8, V1);

    // Test 4: table-driven restart with in_start+in_valid.
    step(1, 0, 0, 0);
    for (int i = 0; i < 11; i++) begin
      step(0, tv[i].st, tv[i].v, tv[i].val);
      chk1("t4_out_valid", oval[0], tv[i].e_ov);
      chk1("t4_dropped", drp[0], tv[i].e_drop);
    end
    chkv("t4_slot0", 128'(ov8[127:112]), 128'd5);
    chkv("t4_vector", ov8, 128'h0005_0006_0007_0008_0009_000A_000B_000C);

    // Test 5: reset between out_valid and sum_valid.
    step(1, 0, 0, 0);
    for (int i = 1; i <= 8; i++) step(0, 0, 1, 16'(i));
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 0, 0);
      if (sval[0]) seen = 1;
    end
    chk1("t5_sum_cancelled", seen, 1'b0);
    chkv("t5_vector_cleared", ov8, 128'h0);
    seen = 0;
    for (int i = 1; i <= 12; i++) begin
      step(0, 0, i <= 8, 16'(i));
      if (sval[0]) begin
        seen = 1;
        chkv("t5_tree_sum", 128'(tsum(ov8, 8)), 128'd36);
      end
    end
    chk1("t5_sum_seen", seen, 1'b1);

    // Test 6: saturated samples and IN_NUM=5 depth.
    step(1, 0, 0, 0);
    ov_c = -1; sv_c = -1;
    for (int i = 0; i < 14; i++) begin
      step(0, 0, i < 8, 16'hFFFF);
      if (oval[2] && ov_c < 0) ov_c = cyc;
      if (sval[2] && sv_c < 0) sv_c = cyc;
      if (sval[0]) chkv("t6_tree_sum_ffff", 128'(tsum(ov8, 8)), 128'hFFF8);
    end
    chkv("t6_n5_sum_latency", 128'(sv_c - ov_c), 128'd3);

    // Randomized stream against the model.
    for (int i = 0; i < 1500; i++)
      step($urandom_range(99) == 0, $urandom_range(11) == 0,
           $urandom_range(3) != 0, 16'($urandom));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
